// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg
//   Shared constants and types for the operand fetch slice.
//   - DEF_DATA_W : default operand / register width in bits
//   - DEF_NREG   : default number of general registers
//   - DEF_ADDR_W : register index width, log2(DEF_NREG)
//   - of_state_t : output-stage state encoding (EMPTY=0, FULL=1)
package operand_fetch_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NREG   = 4;
  localparam int DEF_ADDR_W = $clog2(DEF_NREG);

  // The state value doubles as out_valid, so the encoding is fixed.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } of_state_t;

endpackage

// File: rtl/regfile_4x8.sv
// regfile_4x8
//   General register storage: one synchronous write port and two
//   combinational read ports. All entries clear asynchronously on rst.
//   Ports:
//     clk, rst               : clock, asynchronous active-high reset
//     wr_en, wr_addr, wr_data: write port, applied on the rising edge
//     rd_addr_a, rd_data_a   : read port A (combinational)
//     rd_addr_b, rd_data_b   : read port B (combinational)
//   Reads return the stored value only; write-to-read forwarding is
//   handled by the caller.
module regfile_4x8
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch
//   Reads two operands from a small register file and presents them,
//   together with a registered select bit, to a downstream byte mux
//   through a one-entry output stage.
//   Ports:
//     clk, rst                    : clock, asynchronous active-high reset
//     wr_en, wr_addr, wr_data     : register file write port
//     in_valid, in_ready          : request handshake
//     src_a, src_b, sel_in        : request payload (operand indices, select)
//     out_valid, out_ready        : bundle handshake toward the mux
//     in0, in1, select            : operand bundle driven into the mux
//     fetch_count                 : accepted requests, modulo 256
//
//   Handshake: a transfer happens on a rising edge where valid and ready
//   are both high. in_ready = !rst && (EMPTY || out_ready), so a FULL
//   stage that is being drained can take the next request in the same
//   cycle with no bubble. out_valid is held until out_ready is seen;
//   the bundle does not change while out_valid=1 and out_ready=0.
//
//   The output-stage state is observable directly: out_valid is the
//   state register (EMPTY=0, FULL=1).
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic              sel_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] in1,
  output logic              select,
  output logic [7:0]        fetch_count
);

  of_state_t         state_q;
  of_state_t         state_d;
  logic              accept;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              hit_a;
  logic              hit_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  regfile_4x8 #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (src_a),
    .rd_data_a (rd_a),
    .rd_addr_b (src_b),
    .rd_data_b (rd_b)
  );

  // Forward a same-cycle write so an accepted request sees the value
  // being written rather than the stale entry.
  assign hit_a = wr_en && (wr_addr == src_a);
  assign hit_b = wr_en && (wr_addr == src_b);
  assign op_a  = hit_a ? wr_data : rd_a;
  assign op_b  = hit_b ? wr_data : rd_b;

  // rst gates in_ready so nothing is accepted while reset is held.
  assign in_ready = !rst && ((state_q == EMPTY) || out_ready);
  assign accept   = in_valid && in_ready;

  // Output-stage state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = FULL;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  assign out_valid = (state_q == FULL);

  // Bundle registers only load on acceptance; they hold their last value
  // after the bundle drains so the mux inputs stay quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in0    <= '0;
      in1    <= '0;
      select <= 1'b0;
    end else if (accept) begin
      in0    <= op_a;
      in1    <= op_b;
      select <= sel_in;
    end
  end

  // Accepted-request counter, wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 8'd0;
    end else if (accept) begin
      fetch_count <= fetch_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch
//   Directed self-checking bench for operand_fetch. Inputs change 1 ns
//   after the rising edge; outputs are checked 1 ns after the edge.
module tb_operand_fetch;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic       sel_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       select;
  logic [7:0] fetch_count;

  int n_pass;
  int n_total;

  operand_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src_a       (src_a),
    .src_b       (src_b),
    .sel_in      (sel_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .in0         (in0),
    .in1         (in1),
    .select      (select),
    .fetch_count (fetch_count)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en     = 1'b0;
    wr_addr   = 2'd0;
    wr_data   = 8'h00;
    in_valid  = 1'b0;
    src_a     = 2'd0;
    src_b     = 2'd0;
    sel_in    = 1'b0;
    out_ready = 1'b0;
  endtask

  // Checks the whole visible bundle against expected values.
  task automatic check_bundle(input string name, input logic ev, input logic [7:0] e0,
                              input logic [7:0] e1, input logic es, input logic [7:0] efc);
    n_total++;
    if (out_valid !== ev) $display("FAIL %s out_valid got %b want %b", name, out_valid, ev);
    else n_pass++;
    n_total++;
    if (in0 !== e0) $display("FAIL %s in0 got %h want %h", name, in0, e0);
    else n_pass++;
    n_total++;
    if (in1 !== e1) $display("FAIL %s in1 got %h want %h", name, in1, e1);
    else n_pass++;
    n_total++;
    if (select !== es) $display("FAIL %s select got %b want %b", name, select, es);
    else n_pass++;
    n_total++;
    if (fetch_count !== efc) $display("FAIL %s fetch_count got %0d want %0d", name, fetch_count, efc);
    else n_pass++;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    // Reset mid-cycle with a write and a request pending: both must be ignored.
    rst      = 1'b1;
    wr_en    = 1'b1;
    wr_addr  = 2'd3;
    wr_data  = 8'h77;
    in_valid = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready);
    else n_pass++;
    check_bundle("reset_immediate", 1'b0, 8'h00, 8'h00, 1'b0, 8'd0);
    tick();
    #2;
    rst      = 1'b0;
    wr_en    = 1'b0;
    in_valid = 1'b1;
    src_a    = 2'd0;
    src_b    = 2'd3;
    sel_in   = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    check_bundle("reset_first_fetch", 1'b1, 8'h00, 8'h00, 1'b0, 8'd1);
  endtask

  task automatic test_write_read();
    // Stage is FULL with out_ready=0; a write alone must not disturb it.
    wr_en   = 1'b1;
    wr_addr = 2'd1;
    wr_data = 8'hFF;
    src_a   = 2'd1;
    tick();
    wr_en = 1'b0;
    check_bundle("write_no_accept", 1'b1, 8'h00, 8'h00, 1'b0, 8'd1);
    in_valid  = 1'b1;
    src_a     = 2'd1;
    src_b     = 2'd2;
    sel_in    = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_bundle("write_then_read", 1'b1, 8'hFF, 8'h00, 1'b1, 8'd2);
    tick();
    check_bundle("drain_holds_values", 1'b0, 8'hFF, 8'h00, 1'b1, 8'd2);
  endtask

  task automatic test_bypass();
    out_ready = 1'b0;
    wr_en     = 1'b1;
    wr_addr   = 2'd2;
    wr_data   = 8'hA5;
    in_valid  = 1'b1;
    src_a     = 2'd2;
    src_b     = 2'd2;
    sel_in    = 1'b0;
    tick();
    check_bundle("bypass_both", 1'b1, 8'hA5, 8'hA5, 1'b0, 8'd3);
    // Drain and fetch in the same cycle, bypassing only operand 0.
    out_ready = 1'b1;
    wr_addr   = 2'd0;
    wr_data   = 8'h11;
    src_a     = 2'd0;
    src_b     = 2'd1;
    tick();
    wr_en     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_bundle("bypass_a_only", 1'b1, 8'h11, 8'hFF, 1'b0, 8'd4);
  endtask

  task automatic test_backpressure();
    in_valid  = 1'b1;
    src_a     = 2'd1;
    src_b     = 2'd2;
    sel_in    = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      wr_en   = (c == 0);
      wr_addr = 2'd1;
      wr_data = 8'h3C;
      #1;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d got %b want 0", c, in_ready);
      else n_pass++;
      tick();
      check_bundle("bp_hold", 1'b1, 8'h11, 8'hFF, 1'b0, 8'd4);
    end
    wr_en     = 1'b0;
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    check_bundle("bp_release", 1'b1, 8'h3C, 8'hA5, 1'b1, 8'd5);
    tick();
    check_bundle("bp_drain", 1'b0, 8'h3C, 8'hA5, 1'b1, 8'd5);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_reg [4];
    logic [7:0] e0;
    logic [7:0] e1;
    int         errs;
    // Fresh reset so the count lands on 300 mod 256.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    idle_inputs();
    exp_reg[0] = 8'h12;
    exp_reg[1] = 8'h34;
    exp_reg[2] = 8'h56;
    exp_reg[3] = 8'h00;
    for (int r = 0; r < 3; r++) begin
      wr_en   = 1'b1;
      wr_addr = 2'(r);
      wr_data = exp_reg[r];
      tick();
    end
    errs      = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      // r3 is rewritten every cycle, so reads of r3 exercise the bypass.
      wr_en   = 1'b1;
      wr_addr = 2'd3;
      wr_data = 8'(i);
      src_a   = 2'(i % 4);
      src_b   = 2'((i + 1) % 4);
      sel_in  = i[0];
      e0 = (src_a == 2'd3) ? 8'(i) : exp_reg[src_a];
      e1 = (src_b == 2'd3) ? 8'(i) : exp_reg[src_b];
      exp_reg[3] = 8'(i);
      #1;
      if (in_ready !== 1'b1) errs++;
      tick();
      if (out_valid !== 1'b1 || in0 !== e0 || in1 !== e1 || select !== i[0]) begin
        if (errs < 4)
          $display("FAIL stream_%0d got v=%b %h %h %b want v=1 %h %h %b",
                   i, out_valid, in0, in1, select, e0, e1, i[0]);
        errs++;
      end
    end
    in_valid = 1'b0;
    wr_en    = 1'b0;
    n_total++;
    if (errs != 0) $display("FAIL stream_errors got %0d want 0", errs);
    else n_pass++;
    n_total++;
    if (fetch_count !== 8'd44) $display("FAIL stream_count got %0d want 44", fetch_count);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL stream_drain got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    src_a     = 2'd1;
    src_b     = 2'd0;
    sel_in    = 1'b1;
    tick();
    in_valid = 1'b0;
    check_bundle("ar_full", 1'b1, 8'h34, 8'h12, 1'b1, 8'd45);
    #2;
    rst = 1'b1;
    #1;
    check_bundle("ar_immediate", 1'b0, 8'h00, 8'h00, 1'b0, 8'd0);
    tick();
    #2;
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    check_bundle("ar_dropped", 1'b0, 8'h00, 8'h00, 1'b0, 8'd0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
